// File: rtl/rf_port_arb_pkg.sv
// Shared CPU types for the register-file port arbiter.
// Register ids, arbiter state encoding and address range helper.
package rf_port_arb_pkg;

  localparam int unsigned REG_ID_W     = 3;
  localparam int unsigned NUM_REGS_DEF = 5;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  function automatic logic addr_ok(
    input reg_id_t     a,
    input int unsigned n
  );
    return 32'(a) < n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a last-owner register.
// The current grant is forwarded so a held pair alternates.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic gnt_i,
  input  logic gnt_b_i,
  output logic pick_b_o
);

  logic last_b_q;
  logic last_b;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_b_q <= 1'b1;
    end else if (gnt_i) begin
      last_b_q <= gnt_b_i;
    end
  end

  assign last_b   = gnt_i ? gnt_b_i : last_b_q;
  assign pick_b_o = b_req_i && (!a_req_i || !last_b);

endmodule

// File: rtl/rf_port_arb.sv
// Shares one register-file port between decode (A) and execute (B).
// State names the owner of the port for the current cycle.
module rf_port_arb
  import rf_port_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  reg_id_t           a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  reg_id_t           b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              a_gnt_o,
  output logic              b_gnt_o,
  output logic              a_rvalid_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output reg_id_t           rf_addr_o,
  output logic              rf_we_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [DATA_W-1:0] rf_rdata_i
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              pick_b;
  logic              gnt;
  logic              own_we;
  logic              own_ok;
  reg_id_t           own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [DATA_W-1:0] rd_val;
  logic              a_rd;
  logic              b_rd;

  assign a_gnt_o = (state_q == OWN_A) && a_req_i;
  assign b_gnt_o = (state_q == OWN_B) && b_req_i;
  assign gnt     = a_gnt_o || b_gnt_o;

  rr_arb2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .a_req_i  (a_req_i),
    .b_req_i  (b_req_i),
    .gnt_i    (gnt),
    .gnt_b_i  (b_gnt_o),
    .pick_b_o (pick_b)
  );

  always_comb begin
    state_d = IDLE;
    unique case ({a_req_i, b_req_i})
      2'b11:   state_d = pick_b ? OWN_B : OWN_A;
      2'b10:   state_d = OWN_A;
      2'b01:   state_d = OWN_B;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_addr  = '0;
    own_we    = 1'b0;
    own_wdata = '0;
    unique case (1'b1)
      a_gnt_o: begin
        own_addr  = a_addr_i;
        own_we    = a_we_i;
        own_wdata = a_wdata_i;
      end
      b_gnt_o: begin
        own_addr  = b_addr_i;
        own_we    = b_we_i;
        own_wdata = b_wdata_i;
      end
      default: ;
    endcase
  end

  // Out-of-range ids still get a grant but never touch the file.
  assign own_ok     = addr_ok(own_addr, NUM_REGS);
  assign rf_addr_o  = own_addr;
  assign rf_we_o    = own_we && own_ok;
  assign rf_wdata_o = own_wdata;
  assign rd_val     = own_ok ? rf_rdata_i : '0;

  assign a_rd = a_gnt_o && !a_we_i;
  assign b_rd = b_gnt_o && !b_we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a_rvalid_o <= 1'b0;
      b_rvalid_o <= 1'b0;
      a_rdata_o  <= '0;
      b_rdata_o  <= '0;
    end else begin
      state_q    <= state_d;
      a_rvalid_o <= a_rd;
      b_rvalid_o <= b_rd;
      if (a_rd) a_rdata_o <= rd_val;
      if (b_rd) b_rdata_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_rf_port_arb.sv
// Bench for rf_port_arb: directed scenarios plus random traffic
// checked against a transaction-level model of the shared port.
module tb_rf_port_arb;
  import rf_port_arb_pkg::*;

  localparam int NUM = 5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_req_i = 0, b_req_i = 0;
  logic        a_we_i = 0, b_we_i = 0;
  reg_id_t     a_addr_i = '0, b_addr_i = '0;
  logic [15:0] a_wdata_i = '0, b_wdata_i = '0;
  logic        a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o;
  logic [15:0] a_rdata_o, b_rdata_o;
  reg_id_t     rf_addr_o;
  logic        rf_we_o;
  logic [15:0] rf_wdata_o;
  logic [15:0] rf_rdata_i;

  logic [15:0] rf_mem [8];
  logic [15:0] ref_mem [8];

  int m_own, m_last;
  logic m_rv_a, m_rv_b;
  logic [15:0] m_rd_a, m_rd_b;
  logic g_a, g_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  assign rf_rdata_i = (32'(rf_addr_o) < NUM) ? rf_mem[rf_addr_o]
                                             : 16'hDEAD;

  rf_port_arb dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_req_i    (a_req_i),
    .a_we_i     (a_we_i),
    .a_addr_i   (a_addr_i),
    .a_wdata_i  (a_wdata_i),
    .b_req_i    (b_req_i),
    .b_we_i     (b_we_i),
    .b_addr_i   (b_addr_i),
    .b_wdata_i  (b_wdata_i),
    .a_gnt_o    (a_gnt_o),
    .b_gnt_o    (b_gnt_o),
    .a_rvalid_o (a_rvalid_o),
    .b_rvalid_o (b_rvalid_o),
    .a_rdata_o  (a_rdata_o),
    .b_rdata_o  (b_rdata_o),
    .rf_addr_o  (rf_addr_o),
    .rf_we_o    (rf_we_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_rdata_i (rf_rdata_i)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_last = 2;
    m_rv_a = 1'b0;
    m_rv_b = 1'b0;
    m_rd_a = '0;
    m_rd_b = '0;
    g_a    = 1'b0;
    g_b    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_agnt"}, 32'(a_gnt_o), 32'(0));
    check({tag, "_bgnt"}, 32'(b_gnt_o), 32'(0));
    check({tag, "_arv"}, 32'(a_rvalid_o), 32'(0));
    check({tag, "_brv"}, 32'(b_rvalid_o), 32'(0));
    check({tag, "_ard"}, 32'(a_rdata_o), 32'(0));
    check({tag, "_brd"}, 32'(b_rdata_o), 32'(0));
    check({tag, "_we"}, 32'(rf_we_o), 32'(0));
    check({tag, "_addr"}, 32'(rf_addr_o), 32'(0));
  endtask

  // Returns on a falling edge with reset released.
  task automatic apply_reset();
    rst_i = 1'b1;
    #1;
    check_all_zero("rst");
    @(posedge clk_i);
    #1;
    check_all_zero("rst_hold");
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic set_mem(input int idx, input logic [15:0] v);
    rf_mem[idx]  = v;
    ref_mem[idx] = v;
  endtask

  // One clock cycle: compare against the model, then advance it.
  task automatic cycle();
    logic ga, gb, we_e, wr, ok;
    reg_id_t ad_e, wa;
    logic [15:0] wd_e, wdd;
    #3;
    ga   = (m_own == 1) && a_req_i;
    gb   = (m_own == 2) && b_req_i;
    we_e = 1'b0;
    ad_e = '0;
    wd_e = '0;
    if (ga) begin
      ad_e = a_addr_i;
      wd_e = a_wdata_i;
      we_e = a_we_i && (32'(a_addr_i) < NUM);
    end
    if (gb) begin
      ad_e = b_addr_i;
      wd_e = b_wdata_i;
      we_e = b_we_i && (32'(b_addr_i) < NUM);
    end
    check("a_gnt", 32'(a_gnt_o), 32'(ga));
    check("b_gnt", 32'(b_gnt_o), 32'(gb));
    check("rf_we", 32'(rf_we_o), 32'(we_e));
    check("rf_addr", 32'(rf_addr_o), 32'(ad_e));
    check("rf_wdata", 32'(rf_wdata_o), 32'(wd_e));
    check("a_rvalid", 32'(a_rvalid_o), 32'(m_rv_a));
    check("b_rvalid", 32'(b_rvalid_o), 32'(m_rv_b));
    check("a_rdata", 32'(a_rdata_o), 32'(m_rd_a));
    check("b_rdata", 32'(b_rdata_o), 32'(m_rd_b));
    wr  = rf_we_o;
    wa  = rf_addr_o;
    wdd = rf_wdata_o;
    m_rv_a = 1'b0;
    m_rv_b = 1'b0;
    if (ga) begin
      ok = 32'(a_addr_i) < NUM;
      if (a_we_i) begin
        if (ok) ref_mem[a_addr_i] = a_wdata_i;
      end else begin
        m_rv_a = 1'b1;
        m_rd_a = ok ? ref_mem[a_addr_i] : 16'h0;
      end
      m_last = 1;
    end
    if (gb) begin
      ok = 32'(b_addr_i) < NUM;
      if (b_we_i) begin
        if (ok) ref_mem[b_addr_i] = b_wdata_i;
      end else begin
        m_rv_b = 1'b1;
        m_rd_b = ok ? ref_mem[b_addr_i] : 16'h0;
      end
      m_last = 2;
    end
    if (a_req_i && b_req_i) m_own = (m_last == 1) ? 2 : 1;
    else if (a_req_i)       m_own = 1;
    else if (b_req_i)       m_own = 2;
    else                    m_own = 0;
    g_a = ga;
    g_b = gb;
    @(posedge clk_i);
    #1;
    if (wr) rf_mem[wa] = wdd;
  endtask

  task automatic drive_a(input logic r, input logic w,
                         input reg_id_t ad, input logic [15:0] d);
    a_req_i = r; a_we_i = w; a_addr_i = ad; a_wdata_i = d;
  endtask

  task automatic drive_b(input logic r, input logic w,
                         input reg_id_t ad, input logic [15:0] d);
    b_req_i = r; b_we_i = w; b_addr_i = ad; b_wdata_i = d;
  endtask

  initial begin
    int ca, cb, alt_err;
    logic pa;
    for (int i = 0; i < 8; i++) set_mem(i, 16'($urandom));
    model_reset();
    apply_reset();

    // Uncontended read latency
    set_mem(1, 16'h00AB);
    drive_a(1, 0, 3'd1, 16'h0);
    cycle();
    check("r33_gnt", 32'(a_gnt_o), 32'(1));
    cycle();
    drive_a(0, 0, 3'd0, 16'h0);
    check("r33_rv", 32'(a_rvalid_o), 32'(1));
    check("r33_rd", 32'(a_rdata_o), 32'h00AB);
    cycle();
    check("r33_rv_pulse", 32'(a_rvalid_o), 32'(0));

    // Simultaneous first requests: A then B, no gap
    apply_reset();
    drive_a(1, 0, 3'd0, 16'h0);
    drive_b(1, 0, 3'd3, 16'h0);
    cycle();
    check("r34_a_first", 32'(a_gnt_o), 32'(1));
    cycle();
    drive_a(0, 0, 3'd0, 16'h0);
    check("r34_b_next", 32'(b_gnt_o), 32'(1));
    cycle();
    drive_b(0, 0, 3'd0, 16'h0);
    cycle();

    // B writes, A reads back
    drive_b(1, 1, 3'd2, 16'h0042);
    cycle();
    check("r35_bgnt", 32'(b_gnt_o), 32'(1));
    check("r35_we", 32'(rf_we_o), 32'(1));
    check("r35_wd", 32'(rf_wdata_o), 32'h0042);
    cycle();
    drive_b(0, 0, 3'd0, 16'h0);
    drive_a(1, 0, 3'd2, 16'h0);
    cycle();
    cycle();
    check("r35_agnt", 32'(a_gnt_o), 32'(1));
    cycle();
    drive_a(0, 0, 3'd0, 16'h0);
    check("r35_rd", 32'(a_rdata_o), 32'h0042);
    cycle();

    // Both held: strict alternation
    set_mem(0, 16'h5A5A);
    drive_a(1, 0, 3'd0, 16'h0);
    drive_b(1, 0, 3'd1, 16'h0);
    cycle();
    ca = 0; cb = 0; alt_err = 0; pa = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (a_gnt_o) ca++;
      if (b_gnt_o) cb++;
      if (a_gnt_o == b_gnt_o) alt_err++;
      if (i > 0 && a_gnt_o == pa) alt_err++;
      pa = a_gnt_o;
      cycle();
    end
    check("r36_cnt_a", 32'(ca), 32'(4));
    check("r36_cnt_b", 32'(cb), 32'(4));
    check("r36_alt", 32'(alt_err), 32'(0));
    drive_a(0, 0, 3'd0, 16'h0);
    drive_b(0, 0, 3'd0, 16'h0);
    cycle();
    cycle();

    // Out-of-range register id
    drive_a(1, 1, 3'd6, 16'h1234);
    cycle();
    check("r37_wgnt", 32'(a_gnt_o), 32'(1));
    check("r37_we", 32'(rf_we_o), 32'(0));
    cycle();
    drive_a(1, 0, 3'd6, 16'h0);
    check("r37_rgnt", 32'(a_gnt_o), 32'(1));
    cycle();
    drive_a(0, 0, 3'd0, 16'h0);
    check("r37_rv", 32'(a_rvalid_o), 32'(1));
    check("r37_rd", 32'(a_rdata_o), 32'(0));
    cycle();

    // Reset right after a read grant, request held through it
    drive_a(1, 0, 3'd1, 16'h0);
    cycle();
    check("r38_gnt", 32'(a_gnt_o), 32'(1));
    @(negedge clk_i);
    apply_reset();
    cycle();
    check("r30_gnt", 32'(a_gnt_o), 32'(1));
    cycle();
    drive_a(0, 0, 3'd0, 16'h0);
    cycle();

    // Random traffic obeying the hold-until-grant protocol
    for (int i = 0; i < 600; i++) begin
      if (!a_req_i || g_a)
        drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                reg_id_t'($urandom_range(0, 7)), 16'($urandom));
      if (!b_req_i || g_b)
        drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                reg_id_t'($urandom_range(0, 7)), 16'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
